// File: rtl/sqw_pkg.sv
// Shared definitions for the multi-channel DDS square/PWM generator.
//   - cfg_field_e : register-port field selector (step/duty/amp/offset)
//   - DUTY_xx     : legacy duty presets for 8-bit duty thresholds
//   - sqw_cfg_t   : per-channel configuration record at default widths
package sqw_pkg;

  typedef enum logic [1:0] {
    CFG_STEP = 2'd0,
    CFG_DUTY = 2'd1,
    CFG_AMP  = 2'd2,
    CFG_OFFS = 2'd3
  } cfg_field_e;

  // 0x1A/256 is ~10 %, the others are exact
  localparam logic [7:0] DUTY_10 = 8'h1A;
  localparam logic [7:0] DUTY_25 = 8'h40;
  localparam logic [7:0] DUTY_50 = 8'h80;

  localparam int DEF_PHASE_W = 32;
  localparam int DEF_DUTY_W  = 8;
  localparam int DEF_OUT_W   = 24;

  typedef struct packed {
    logic [DEF_PHASE_W-1:0] step;
    logic [DEF_PHASE_W-1:0] offs;
    logic [DEF_DUTY_W-1:0]  duty;
    logic [DEF_OUT_W-2:0]   amp;
  } sqw_cfg_t;

endpackage

// File: rtl/square_wave_gen_mc_if.sv
// Configuration write port of square_wave_gen_mc (valid/ready).
//   cfg_valid/cfg_ch/cfg_field/cfg_data : request, driven by master
//   cfg_ready                           : accept, driven by slave
interface square_wave_gen_mc_if #(
  parameter int NUM_CH  = 4,
  parameter int PHASE_W = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic               cfg_valid;
  logic               cfg_ready;
  logic [CH_W-1:0]    cfg_ch;
  logic [1:0]         cfg_field;
  logic [PHASE_W-1:0] cfg_data;

  modport master (output cfg_valid, cfg_ch, cfg_field, cfg_data, input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_ch, cfg_field, cfg_data, output cfg_ready);
endinterface

// File: rtl/sqw_channel.sv
// One DDS square/PWM channel: phase accumulator, shadow/active config,
// duty compare and registered signed output.
//   clk, reset (async, active low)
//   en     : run enable; output and accumulator freeze when low
//   sync   : zero accumulator, commit all pending fields
//   wr/field/data : accepted config write for this channel
//   pend   : per-field pending flags (drive the top-level ready mux)
//   sample : +amp / -amp, two's complement
//   wrap   : one-cycle pulse alongside the wrapped accumulator value
// Optional macro SQW_PHASE_OFFSET_EN adds a per-channel phase offset in
// the compare path; without it field 3 writes are dropped.
module sqw_channel
  import sqw_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int DUTY_W  = 8,
  parameter int OUT_W   = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               sync,
  input  logic               wr,
  input  cfg_field_e         field,
  input  logic [PHASE_W-1:0] data,
  output logic [3:0]         pend,
  output logic [OUT_W-1:0]   sample,
  output logic               wrap
);

  typedef struct packed {
    logic [PHASE_W-1:0] step;
`ifdef SQW_PHASE_OFFSET_EN
    logic [PHASE_W-1:0] offs;
`endif
    logic [DUTY_W-1:0]  duty;
    logic [OUT_W-2:0]   amp;
  } cfg_t;

  cfg_t               act, shd;
  logic [PHASE_W-1:0] acc, ph;
  logic [PHASE_W:0]   sum;
  logic [3:0]         wmask;
  logic [OUT_W-1:0]   mag;
  logic               carry, commit, hi;
  logic               unused_ph;

  assign sum   = {1'b0, acc} + {1'b0, act.step};
  assign carry = sum[PHASE_W];
  // Shadows land at the wrap edge so a period never mixes old and new
  // settings; an idle channel has no period to protect.
  assign commit = sync | ~en | carry;

`ifdef SQW_PHASE_OFFSET_EN
  assign ph    = acc + act.offs;
  assign wmask = {4{wr}} & (4'b0001 << field);
`else
  assign ph    = acc;
  // offset writes complete the handshake but leave no state behind
  assign wmask = {4{wr}} & (4'b0001 << field) & 4'b0111;
`endif

  assign hi        = ph[PHASE_W-1 -: DUTY_W] < act.duty;
  assign mag       = {1'b0, act.amp};
  assign unused_ph = ^ph[PHASE_W-DUTY_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      act    <= '0;
      shd    <= '0;
      pend   <= '0;
      sample <= '0;
      wrap   <= 1'b0;
    end else begin
      if (sync)    acc <= '0;
      else if (en) acc <= sum[PHASE_W-1:0];
      wrap <= en & carry & ~sync;
      if (en) sample <= hi ? mag : -mag;

      if (commit) begin
        if (pend[CFG_STEP]) act.step <= shd.step;
        if (pend[CFG_DUTY]) act.duty <= shd.duty;
        if (pend[CFG_AMP])  act.amp  <= shd.amp;
`ifdef SQW_PHASE_OFFSET_EN
        if (pend[CFG_OFFS]) act.offs <= shd.offs;
`endif
      end

      if (wmask[CFG_STEP]) shd.step <= data;
      if (wmask[CFG_DUTY]) shd.duty <= data[DUTY_W-1:0];
      if (wmask[CFG_AMP])  shd.amp  <= data[OUT_W-2:0];
`ifdef SQW_PHASE_OFFSET_EN
      if (wmask[CFG_OFFS]) shd.offs <= data;
`endif
      // a write only lands on a non-pending field, so clear-then-set is safe
      pend <= (commit ? 4'b0000 : pend) | wmask;
    end
  end

endmodule

// File: rtl/square_wave_gen_mc.sv
// Multi-channel DDS square/PWM generator top.
//   clk, reset (async, active low)
//   ch_en       : per-channel run enable
//   sync        : one-cycle pulse, zeroes all accumulators
//   cfg         : config write port (square_wave_gen_mc_if.slave)
//   square_wave : packed signed samples, channel 0 in the LSBs
//   wrap        : per-channel accumulator wrap pulse
// Optional macro SQW_PHASE_OFFSET_EN enables the per-channel phase offset.
module square_wave_gen_mc
  import sqw_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int PHASE_W = 32,
  parameter int DUTY_W  = 8,
  parameter int OUT_W   = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     sync,
  square_wave_gen_mc_if.slave      cfg,
  output logic [NUM_CH*OUT_W-1:0]  square_wave,
  output logic [NUM_CH-1:0]        wrap
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0][3:0]       pend;
  logic [NUM_CH-1:0][OUT_W-1:0] smp;
  logic [NUM_CH-1:0]            wr;
  logic                         rdy;

  // Ready follows the addressed field's pending flag; addresses beyond
  // NUM_CH are accepted and go nowhere.
  always_comb begin
    rdy = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (cfg.cfg_ch == CH_W'(i)) rdy = ~pend[i][cfg.cfg_field];
  end
  assign cfg.cfg_ready = rdy;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr[i] = cfg.cfg_valid & rdy & (cfg.cfg_ch == CH_W'(i));

    sqw_channel #(
      .PHASE_W (PHASE_W),
      .DUTY_W  (DUTY_W),
      .OUT_W   (OUT_W)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .en     (ch_en[i]),
      .sync   (sync),
      .wr     (wr[i]),
      .field  (cfg_field_e'(cfg.cfg_field)),
      .data   (cfg.cfg_data),
      .pend   (pend[i]),
      .sample (smp[i]),
      .wrap   (wrap[i])
    );
  end

  assign square_wave = smp;

endmodule
